// File: rtl/stage_3.sv
// stage_3: range-encoder renormalization stage.
// Shifts range up until its MSB is set, shifts low by the same amount while
// dropping bits already committed to pending output bytes, and advances the
// bit count. All outputs are registered, one cycle of latency.
module stage_3 #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24,
    parameter int D_SIZE      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic [RANGE_WIDTH-1:0] range,
    input  logic [LOW_WIDTH-1:0]   low,
    input  logic [D_SIZE-1:0]      in_s,
    output logic                   valid_out,
    output logic [RANGE_WIDTH-1:0] out_range,
    output logic [LOW_WIDTH-1:0]   out_low,
    output logic [D_SIZE-1:0]      out_s
);

    localparam int DW = $clog2(RANGE_WIDTH);

    // Leading-zero count; the highest set bit wins, and an all-zero range
    // (illegal) falls out as 0 so everything passes through unchanged.
    function automatic logic [DW-1:0] lzc(input logic [RANGE_WIDTH-1:0] r);
        logic [DW-1:0] n;
        n = '0;
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (r[i]) n = DW'(RANGE_WIDTH - 1 - i);
        end
        return n;
    endfunction

    logic [DW-1:0]          d;
    logic signed [7:0]      d_ext;
    logic signed [7:0]      cnt;
    logic signed [7:0]      s;
    logic signed [7:0]      c;
    logic signed [7:0]      new_cnt;
    logic [LOW_WIDTH-1:0]   mask;

    logic                   valid_out_d, valid_out_q;
    logic [RANGE_WIDTH-1:0] out_range_d, out_range_q;
    logic [LOW_WIDTH-1:0]   out_low_d,   out_low_q;
    logic [D_SIZE-1:0]      out_s_d,     out_s_q;

    // Normalization arithmetic and the load/hold selection for the output flops.
    always_comb begin
        d     = lzc(range);
        d_ext = $signed(8'(d));
        cnt   = $signed(8'(in_s)) - 8'sd9;
        s     = cnt + d_ext;

        // c is the number of low bits still uncommitted once the pending
        // byte(s) are accounted for; bits at and above c are discarded.
        c = 8'sd0;
        if (s >= 8'sd8)      c = cnt + 8'sd8;
        else if (s >= 8'sd0) c = cnt + 8'sd16;

        if (s < 8'sd0) begin
            mask    = '1;
            new_cnt = s;
        end else begin
            mask    = ~({LOW_WIDTH{1'b1}} << c);
            new_cnt = c + d_ext - 8'sd24;
        end

        valid_out_d = valid_in;
        out_range_d = out_range_q;
        out_low_d   = out_low_q;
        out_s_d     = out_s_q;
        if (valid_in) begin
            out_range_d = range << d;
            out_low_d   = (low & mask) << d;
            out_s_d     = D_SIZE'(new_cnt + 8'sd9);
        end
    end

    // Output registers; reset takes priority over a valid sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_q <= 1'b0;
            out_range_q <= RANGE_WIDTH'(1) << (RANGE_WIDTH - 1);
            out_low_q   <= '0;
            out_s_q     <= '0;
        end else begin
            valid_out_q <= valid_out_d;
            out_range_q <= out_range_d;
            out_low_q   <= out_low_d;
            out_s_q     <= out_s_d;
        end
    end

    assign valid_out = valid_out_q;
    assign out_range = out_range_q;
    assign out_low   = out_low_q;
    assign out_s     = out_s_q;

endmodule

// File: tb/tb_stage_3.sv
// Testbench for stage_3: directed vectors with literal expectations, then
// randomized streams checked every cycle against a behavioural model.
module tb_stage_3;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [15:0] range;
    logic [23:0] low;
    logic [3:0]  in_s;
    logic        valid_out;
    logic [15:0] out_range;
    logic [23:0] out_low;
    logic [3:0]  out_s;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state: what the registered outputs must hold after each edge.
    logic        exp_valid;
    logic [15:0] exp_range;
    logic [23:0] exp_low;
    logic [3:0]  exp_s;

    stage_3 #(.RANGE_WIDTH(16), .LOW_WIDTH(24), .D_SIZE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .range     (range),
        .low       (low),
        .in_s      (in_s),
        .valid_out (valid_out),
        .out_range (out_range),
        .out_low   (out_low),
        .out_s     (out_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Renormalization from the arithmetic definition: shift range until its
    // top bit is set, keep only the low bits not yet owed to output bytes.
    function automatic void ref_model(input int r, input int l, input int si,
                                      output int er, output int el, output int es);
        int d, cnt, s, c, nc;
        longint lo;
        d = 0;
        if (r != 0) while (((r << d) & 'h8000) == 0) d++;
        cnt = si - 9;
        s = cnt + d;
        if (s < 0) begin
            lo = longint'(l) << d;
            nc = s;
        end else begin
            c  = (s < 8) ? cnt + 16 : cnt + 8;
            lo = (longint'(l) % (longint'(1) << c)) << d;
            nc = c + d - 24;
        end
        el = int'(lo & 64'hFFFFFF);
        er = (r << d) & 'hFFFF;
        es = (nc + 9) & 'hF;
    endfunction

    // Reference model advanced on the same edge the DUT samples.
    always @(posedge clk) begin
        int er, el, es;
        if (reset) begin
            exp_valid <= 1'b0;
            exp_range <= 16'h8000;
            exp_low   <= 24'h0;
            exp_s     <= 4'h0;
        end else begin
            exp_valid <= valid_in;
            if (valid_in) begin
                ref_model(int'(range), int'(low), int'(in_s), er, el, es);
                exp_range <= er[15:0];
                exp_low   <= el[23:0];
                exp_s     <= es[3:0];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("valid_out", longint'(valid_out), longint'(exp_valid));
            chk("out_range", longint'(out_range), longint'(exp_range));
            chk("out_low",   longint'(out_low),   longint'(exp_low));
            chk("out_s",     longint'(out_s),     longint'(exp_s));
        end
    end

    // Apply one input set across a single clock edge; returns #1 after the edge.
    task automatic apply(input bit v, input logic [15:0] r, input logic [23:0] l,
                         input logic [3:0] si);
        valid_in = v;
        range    = r;
        low      = l;
        in_s     = si;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input bit v, input logic [15:0] r,
                           input logic [23:0] l, input logic [3:0] si);
        chk({name, ".valid"}, longint'(valid_out), longint'(v));
        chk({name, ".range"}, longint'(out_range), longint'(r));
        chk({name, ".low"},   longint'(out_low),   longint'(l));
        chk({name, ".s"},     longint'(out_s),     longint'(si));
    endtask

    initial begin
        int er, el, es;

        // Pin the model itself against hand-computed results.
        ref_model('h0100, 'hABCD, 4, er, el, es);
        chk("model_one_byte.range", er, 'h8000);
        chk("model_one_byte.low",   el, 'h1E680);
        chk("model_one_byte.s",     es, 3);
        ref_model('h0001, 'hFFFFFF, 8, er, el, es);
        chk("model_two_bytes.low",  el, 'h3F8000);
        chk("model_two_bytes.s",    es, 7);
        ref_model('h4000, 'h000100, 0, er, el, es);
        chk("model_shift.low",      el, 'h200);
        chk("model_shift.s",        es, 1);

        reset = 1'b1;
        valid_in = 1'b0; range = '0; low = '0; in_s = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_en = 1'b1;
        chk_out("reset", 1'b0, 16'h8000, 24'h0, 4'h0);
        reset = 1'b0;

        apply(1'b1, 16'h8000, 24'h001234, 4'd0);
        chk_out("normalized", 1'b1, 16'h8000, 24'h001234, 4'd0);
        apply(1'b1, 16'h4000, 24'h000100, 4'd0);
        chk_out("shift", 1'b1, 16'h8000, 24'h000200, 4'd1);
        apply(1'b1, 16'h0100, 24'h00ABCD, 4'd4);
        chk_out("one_byte", 1'b1, 16'h8000, 24'h01E680, 4'd3);
        apply(1'b1, 16'h0001, 24'hFFFFFF, 4'd8);
        chk_out("two_bytes", 1'b1, 16'h8000, 24'h3F8000, 4'd7);

        // Hold for three idle cycles, with junk on the data inputs.
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 16'h0003, 24'h123456, 4'd2);
            chk_out("hold", 1'b0, 16'h8000, 24'h3F8000, 4'd7);
        end

        // range==0 passes range, low and count straight through.
        apply(1'b1, 16'h0000, 24'hABCDEF, 4'd3);
        chk_out("range_zero", 1'b1, 16'h0000, 24'hABCDEF, 4'd3);

        // Reset wins over a simultaneous valid sample.
        reset = 1'b1;
        apply(1'b1, 16'h0100, 24'h00ABCD, 4'd4);
        chk_out("reset_dominates", 1'b0, 16'h8000, 24'h0, 4'h0);
        reset = 1'b0;

        // Stream: each new sample continues from the previous count.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            r = 16'($urandom_range(1, 16'hFFFF) >> $urandom_range(0, 15));
            if (r == 16'h0) r = 16'h1;
            apply(($urandom_range(0, 7) != 0), r, 24'($urandom), exp_s);
        end

        // Unconstrained: illegal counts and zero range mixed in.
        for (int i = 0; i < 200; i++) begin
            logic [15:0] r;
            r = 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(0, 16));
            apply(($urandom_range(0, 3) != 0), r, 24'($urandom), 4'($urandom));
        end

        apply(1'b0, 16'h0, 24'h0, 4'h0);
        @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
